costas_acq_ctrl: RTL and testbench
==================================

Name: costas_acq_ctrl

Overview:
Acquisition/tracking sequencer for the BPSK Costas demodulator loop. Watches the loop's I/Q arm outputs over fixed windows and computes a lock metric. Steps a carrier-frequency offset sweep and switches loop-filter gains between wide (pull-in) and narrow (track). Sits beside the Costas core: consumes I_out/Q_out, drives the NCO offset word, gain selects and a loop-filter clear.

Parameters:
IQ_W, 16, width of signed I/Q inputs
WIN_LOG2, 8, metric window = 2^WIN_LOG2 valid samples
FW, 32, width of signed NCO frequency-offset word
STEP, 32'd85899, sweep step added to the offset word (~1 kHz at 50 MHz, 32-bit NCO)
MAX_STEPS, 8, sweep extent ±MAX_STEPS*STEP
LOCK_CNT, 4, consecutive passing windows PULL_IN -> TRACK
UNLOCK_CNT, 3, consecutive failing windows TRACK -> SWEEP
KP_WIDE, 4, proportional shift in SWEEP/PULL_IN; KI_WIDE, 10, integral shift same states
KP_NARROW, 7, proportional shift in TRACK; KI_NARROW, 14, integral shift in TRACK

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  reset: one clock; reset is synchronous and active-high
en  in  1  1 = run acquisition; 0 = force IDLE
iq_valid  in  1  I/Q sample strobe
i_in  in  IQ_W  signed I arm
q_in  in  IQ_W  signed Q arm
freq_ofs  out  FW  signed NCO offset word
kp_shift  out  4  loop-filter proportional shift
ki_shift  out  4  loop-filter integral shift
loop_clr  out  1  one-cycle pulse clearing loop-filter integrator
locked  out  1  high only in TRACK
state  out  2  00 IDLE, 01 SWEEP, 10 PULL_IN, 11 TRACK

Behaviour:
- Reset: state IDLE, freq_ofs 0, kp_shift KP_WIDE, ki_shift KI_WIDE, loop_clr 0, locked 0, accumulators/counters 0. All outputs registered.
- Abs: |x| with -2^(IQ_W-1) saturated to 2^(IQ_W-1)-1. Accumulators acc_i, acc_q unsigned IQ_W-1+WIN_LOG2 bits, no overflow possible.
- Window: on each iq_valid add |i_in|,|q_in|; sample counter WIN_LOG2 bits. On the valid that wraps the counter to 0: pass = (acc_i_final > 2*acc_q_final), evaluated including that sample; accumulators restart from 0 next sample (no sample lost). win_done is one internal cycle pulse; state decisions happen that cycle, outputs update next cycle.
- Window counting only in SWEEP/PULL_IN/TRACK; cleared on every state change and in IDLE.
- IDLE: en=1 -> SWEEP, freq_ofs 0, loop_clr pulse.
- SWEEP: wide gains. win_done & pass -> PULL_IN, freq_ofs held, pass_cnt=1. win_done & !pass -> next offset in order 0,+S,-S,+2S,-2S,...,+M*S,-M*S, then back to 0; loop_clr pulse on each step.
- PULL_IN: wide gains. pass -> pass_cnt++; pass_cnt reaching LOCK_CNT -> TRACK. fail -> SWEEP advancing to next offset, loop_clr pulse.
- TRACK: narrow gains, locked=1. fail -> fail_cnt++; pass -> fail_cnt=0. fail_cnt reaching UNLOCK_CNT -> SWEEP, freq_ofs 0, sweep index 0, loop_clr pulse, locked 0 next cycle.
- Gains change on the same cycle state changes.
- en=0 in any state: next cycle IDLE, freq_ofs kept, locked 0; overrides a simultaneous win_done.
- sys_rst mid-window: all state lost, back to reset values next edge.
- iq_valid may be held high every cycle; no backpressure.

Decomposition:
- Package costas_pkg: state encoding constants (IDLE/SWEEP/PULL_IN/TRACK), gain-shift widths, default STEP.
- Sub-module iq_window_metric: abs, accumulate, window counter, outputs win_done/pass; top holds FSM, sweep index and offset generator.

Test Plan:
- Reset, en=1, iq_valid every cycle, I=+1000,Q=0 -> SWEEP after 1 cycle, PULL_IN after 256 samples, TRACK (locked=1, kp=7, ki=14) after 1024 samples total.
- I=500,Q=500 constant -> never passes; freq_ofs steps 0,+85899,-85899,+171798,... each 256 samples, wraps to 0 after -687192; loop_clr pulse per step.
- In TRACK, switch to I=Q=500 -> locked drops after exactly 3 windows (768 samples), freq_ofs=0, loop_clr pulse.
- In TRACK, alternate fail/pass windows -> fail_cnt never reaches 3, locked stays 1.
- I=-32768, Q=-16383 -> abs saturation, acc_i=255*... pass true (32767>2*16383); PULL_IN reached.
- en deasserted mid-PULL_IN and sys_rst mid-window -> IDLE next cycle, locked 0; after reset all outputs at reset values.

Source files
------------

// File: rtl/costas_pkg.sv
// Shared encodings and widths for the Costas acquisition sequencer.
package costas_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_SWEEP   = 2'b01,
        ST_PULL_IN = 2'b10,
        ST_TRACK   = 2'b11
    } state_t;

    localparam int unsigned SHIFT_W      = 4;
    localparam int unsigned CNT_W        = 4;
    localparam int unsigned STEP_DEFAULT = 32'd85899;

endpackage

// File: rtl/iq_window_metric.sv
// Windowed |I| / |Q| accumulator producing a per-window lock decision.
module iq_window_metric #(
    parameter int unsigned IQ_W     = 16,
    parameter int unsigned WIN_LOG2 = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic            clr,
    input  logic            iq_valid,
    input  logic [IQ_W-1:0] i_in,
    input  logic [IQ_W-1:0] q_in,
    output logic            win_done_c,
    output logic            pass_c
);

    localparam int unsigned MAG_W = IQ_W - 1;
    localparam int unsigned ACC_W = IQ_W - 1 + WIN_LOG2;

    logic [WIN_LOG2-1:0] cnt;
    logic [ACC_W-1:0]    acc_i;
    logic [ACC_W-1:0]    acc_q;
    logic [ACC_W-1:0]    sum_i;
    logic [ACC_W-1:0]    sum_q;

    // Magnitude with the most negative code clamped to the largest positive one.
    function automatic logic [MAG_W-1:0] abs_sat(input logic [IQ_W-1:0] x);
        logic [IQ_W-1:0] neg;
        neg = -x;
        if (x == {1'b1, {MAG_W{1'b0}}}) return {MAG_W{1'b1}};
        if (x[IQ_W-1])                  return neg[MAG_W-1:0];
        return x[MAG_W-1:0];
    endfunction

    // Running sums including the current sample; decision is made on the wrapping sample.
    always_comb begin
        sum_i      = acc_i + ACC_W'(abs_sat(i_in));
        sum_q      = acc_q + ACC_W'(abs_sat(q_in));
        win_done_c = run & iq_valid & (cnt == '1);
        pass_c     = {1'b0, sum_i} > {sum_q, 1'b0};
    end

    // Sample counter and accumulators; restart at every window boundary or state change.
    always_ff @(posedge clk) begin
        if (rst || !run || clr) begin
            cnt   <= '0;
            acc_i <= '0;
            acc_q <= '0;
        end else if (iq_valid) begin
            cnt <= cnt + WIN_LOG2'(1);
            if (cnt == '1) begin
                acc_i <= '0;
                acc_q <= '0;
            end else begin
                acc_i <= sum_i;
                acc_q <= sum_q;
            end
        end
    end

endmodule

// File: rtl/costas_acq_ctrl.sv
// Costas loop acquisition sequencer: frequency sweep, pull-in and track gain control.
module costas_acq_ctrl
    import costas_pkg::*;
#(
    parameter int unsigned IQ_W       = 16,
    parameter int unsigned WIN_LOG2   = 8,
    parameter int unsigned FW         = 32,
    parameter int unsigned STEP       = STEP_DEFAULT,
    parameter int unsigned MAX_STEPS  = 8,
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned UNLOCK_CNT = 3,
    parameter int unsigned KP_WIDE    = 4,
    parameter int unsigned KI_WIDE    = 10,
    parameter int unsigned KP_NARROW  = 7,
    parameter int unsigned KI_NARROW  = 14
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               en,
    input  logic               iq_valid,
    input  logic [IQ_W-1:0]    i_in,
    input  logic [IQ_W-1:0]    q_in,
    output logic [FW-1:0]      freq_ofs,
    output logic [SHIFT_W-1:0] kp_shift,
    output logic [SHIFT_W-1:0] ki_shift,
    output logic               loop_clr,
    output logic               locked,
    output logic [1:0]         state
);

    localparam int unsigned LAST_IDX = 2 * MAX_STEPS;
    localparam int unsigned IDX_W    = $clog2(LAST_IDX + 1);

    state_t               st_q, st_d;
    logic [FW-1:0]        ofs_q, ofs_d, step_ofs;
    logic [IDX_W-1:0]     idx_q, idx_d, step_idx;
    logic [CNT_W-1:0]     pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0]     fail_cnt_q, fail_cnt_d;
    logic [SHIFT_W-1:0]   kp_q, kp_d, ki_q, ki_d;
    logic                 clr_q, clr_d, locked_q, locked_d;
    logic                 win_done_c, pass_c, chg_c, run_c;

    assign run_c = (st_q != ST_IDLE);

    iq_window_metric #(
        .IQ_W     (IQ_W),
        .WIN_LOG2 (WIN_LOG2)
    ) u_metric (
        .clk        (sys_clk),
        .rst        (sys_rst),
        .run        (run_c),
        .clr        (chg_c),
        .iq_valid   (iq_valid),
        .i_in       (i_in),
        .q_in       (q_in),
        .win_done_c (win_done_c),
        .pass_c     (pass_c)
    );

    // State and registered outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            st_q       <= ST_IDLE;
            ofs_q      <= '0;
            idx_q      <= '0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
            kp_q       <= SHIFT_W'(KP_WIDE);
            ki_q       <= SHIFT_W'(KI_WIDE);
            clr_q      <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            st_q       <= st_d;
            ofs_q      <= ofs_d;
            idx_q      <= idx_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            kp_q       <= kp_d;
            ki_q       <= ki_d;
            clr_q      <= clr_d;
            locked_q   <= locked_d;
        end
    end

    // Next state, sweep stepping (0,+S,-S,+2S,-2S,...) and gain selection.
    always_comb begin
        st_d       = st_q;
        ofs_d      = ofs_q;
        idx_d      = idx_q;
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        clr_d      = 1'b0;

        // Odd index holds +kS so the next is -kS; even holds -kS so the next is +(k+1)S.
        if (idx_q == IDX_W'(LAST_IDX)) begin
            step_idx = '0;
            step_ofs = '0;
        end else begin
            step_idx = idx_q + IDX_W'(1);
            step_ofs = idx_q[0] ? -ofs_q : (FW'(STEP) - ofs_q);
        end

        if (!en) begin
            st_d = ST_IDLE;
        end else begin
            case (st_q)
                ST_IDLE: begin
                    st_d       = ST_SWEEP;
                    ofs_d      = '0;
                    idx_d      = '0;
                    pass_cnt_d = '0;
                    fail_cnt_d = '0;
                    clr_d      = 1'b1;
                end
                ST_SWEEP: begin
                    if (win_done_c) begin
                        if (pass_c) begin
                            st_d       = ST_PULL_IN;
                            pass_cnt_d = CNT_W'(1);
                        end else begin
                            idx_d = step_idx;
                            ofs_d = step_ofs;
                            clr_d = 1'b1;
                        end
                    end
                end
                ST_PULL_IN: begin
                    if (win_done_c) begin
                        if (pass_c) begin
                            pass_cnt_d = pass_cnt_q + CNT_W'(1);
                            if (pass_cnt_d == CNT_W'(LOCK_CNT)) begin
                                st_d       = ST_TRACK;
                                fail_cnt_d = '0;
                            end
                        end else begin
                            st_d  = ST_SWEEP;
                            idx_d = step_idx;
                            ofs_d = step_ofs;
                            clr_d = 1'b1;
                        end
                    end
                end
                ST_TRACK: begin
                    if (win_done_c) begin
                        if (pass_c) begin
                            fail_cnt_d = '0;
                        end else begin
                            fail_cnt_d = fail_cnt_q + CNT_W'(1);
                            if (fail_cnt_d == CNT_W'(UNLOCK_CNT)) begin
                                st_d  = ST_SWEEP;
                                ofs_d = '0;
                                idx_d = '0;
                                clr_d = 1'b1;
                            end
                        end
                    end
                end
                default: st_d = ST_IDLE;
            endcase
        end

        chg_c    = (st_d != st_q);
        locked_d = (st_d == ST_TRACK);
        kp_d     = locked_d ? SHIFT_W'(KP_NARROW) : SHIFT_W'(KP_WIDE);
        ki_d     = locked_d ? SHIFT_W'(KI_NARROW) : SHIFT_W'(KI_WIDE);
    end

    assign freq_ofs = ofs_q;
    assign kp_shift = kp_q;
    assign ki_shift = ki_q;
    assign loop_clr = clr_q;
    assign locked   = locked_q;
    assign state    = st_q;

endmodule

// File: tb/tb_costas_acq_ctrl.sv
// Bench for costas_acq_ctrl: behavioural model compared every cycle plus literal checkpoints.
module tb_costas_acq_ctrl;

    localparam int IQ_W  = 16;
    localparam int WIN   = 256;
    localparam int STEPV = 85899;
    localparam int NOFS  = 17;

    logic              sys_clk = 1'b0;
    logic              sys_rst;
    logic              en;
    logic              iq_valid;
    logic [IQ_W-1:0]   i_in;
    logic [IQ_W-1:0]   q_in;
    logic [31:0]       freq_ofs;
    logic [3:0]        kp_shift;
    logic [3:0]        ki_shift;
    logic              loop_clr;
    logic              locked;
    logic [1:0]        state;

    always #5 sys_clk = ~sys_clk;

    costas_acq_ctrl dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .en       (en),
        .iq_valid (iq_valid),
        .i_in     (i_in),
        .q_in     (q_in),
        .freq_ofs (freq_ofs),
        .kp_shift (kp_shift),
        .ki_shift (ki_shift),
        .loop_clr (loop_clr),
        .locked   (locked),
        .state    (state)
    );

    int checks = 0;
    int passed = 0;

    // Model: 0 IDLE, 1 SWEEP, 2 PULL_IN, 3 TRACK
    int     m_state = 0;
    int     m_idx = 0;
    longint m_ofs = 0;
    int     m_clr = 0;
    int     m_pcnt = 0;
    int     m_fcnt = 0;
    int     win_n = 0;
    longint sum_i = 0;
    longint sum_q = 0;

    function automatic int abs_sat(int x);
        if (x == -32768) return 32767;
        return (x < 0) ? -x : x;
    endfunction

    // Sweep position k -> offset: 0, +S, -S, +2S, -2S, ...
    function automatic longint ofs_of(int idx);
        if (idx == 0) return 0;
        if (idx % 2 == 1) return longint'((idx + 1) / 2) * STEPV;
        return -longint'(idx / 2) * STEPV;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic advance();
        m_idx = (m_idx + 1) % NOFS;
        m_ofs = ofs_of(m_idx);
    endtask

    // Apply one clock of the acquisition rules to the model using the current inputs.
    task automatic model_step();
        int  nxt;
        bit  wd;
        bit  ps;
        if (sys_rst) begin
            m_state = 0; m_idx = 0; m_ofs = 0; m_clr = 0;
            m_pcnt = 0; m_fcnt = 0; win_n = 0; sum_i = 0; sum_q = 0;
            return;
        end
        nxt = m_state; m_clr = 0; wd = 0; ps = 0;
        if (m_state != 0 && iq_valid) begin
            sum_i += abs_sat(int'($signed(i_in)));
            sum_q += abs_sat(int'($signed(q_in)));
            win_n++;
            if (win_n == WIN) begin
                wd = 1;
                ps = (sum_i > 2 * sum_q);
                win_n = 0; sum_i = 0; sum_q = 0;
            end
        end
        if (!en) begin
            nxt = 0;
        end else begin
            case (m_state)
                0: begin nxt = 1; m_idx = 0; m_ofs = 0; m_clr = 1; end
                1: if (wd) begin
                    if (ps) begin nxt = 2; m_pcnt = 1; end
                    else begin advance(); m_clr = 1; end
                end
                2: if (wd) begin
                    if (ps) begin
                        m_pcnt++;
                        if (m_pcnt == 4) begin nxt = 3; m_fcnt = 0; end
                    end else begin nxt = 1; advance(); m_clr = 1; end
                end
                default: if (wd) begin
                    if (ps) m_fcnt = 0;
                    else begin
                        m_fcnt++;
                        if (m_fcnt == 3) begin nxt = 1; m_idx = 0; m_ofs = 0; m_clr = 1; end
                    end
                end
            endcase
        end
        if (nxt != m_state || nxt == 0) begin
            win_n = 0; sum_i = 0; sum_q = 0;
        end
        m_state = nxt;
    endtask

    // One clock: advance the model at the edge, compare all outputs 1 time unit later.
    task automatic cyc();
        @(posedge sys_clk);
        model_step();
        #1;
        chk("state",    longint'(state), m_state);
        chk("freq_ofs", longint'($signed(freq_ofs)), m_ofs);
        chk("kp_shift", longint'(kp_shift), (m_state == 3) ? 7 : 4);
        chk("ki_shift", longint'(ki_shift), (m_state == 3) ? 14 : 10);
        chk("loop_clr", longint'(loop_clr), m_clr);
        chk("locked",   longint'(locked), (m_state == 3) ? 1 : 0);
    endtask

    task automatic run(input int n, input int iv, input int qv);
        for (int k = 0; k < n; k++) begin
            iq_valid = 1'b1;
            i_in = IQ_W'(iv);
            q_in = IQ_W'(qv);
            cyc();
        end
    endtask

    int exp_seq [NOFS] = '{85899, -85899, 171798, -171798, 257697, -257697,
                           343596, -343596, 429495, -429495, 515394, -515394,
                           601293, -601293, 687192, -687192, 0};

    initial begin
        sys_rst = 1'b1; en = 1'b0; iq_valid = 1'b0; i_in = '0; q_in = '0;
        cyc(); cyc();
        chk("rst_state", longint'(state), 0);
        chk("rst_kp", longint'(kp_shift), 4);
        chk("rst_ki", longint'(ki_shift), 10);
        chk("rst_ofs", longint'(freq_ofs), 0);

        // Clean signal: lock in 1024 samples
        sys_rst = 1'b0; en = 1'b1;
        run(1, 1000, 0);
        chk("lit_sweep", longint'(state), 1);
        chk("lit_clr_entry", longint'(loop_clr), 1);
        run(255, 1000, 0);
        chk("lit_still_sweep", longint'(state), 1);
        run(1, 1000, 0);
        chk("lit_pull_in", longint'(state), 2);
        run(767, 1000, 0);
        chk("lit_still_pull", longint'(state), 2);
        run(1, 1000, 0);
        chk("lit_track", longint'(state), 3);
        chk("lit_locked", longint'(locked), 1);
        chk("lit_kp_narrow", longint'(kp_shift), 7);
        chk("lit_ki_narrow", longint'(ki_shift), 14);

        // Loss of lock after exactly three failing windows
        run(767, 500, 500);
        chk("lit_track_hold", longint'(locked), 1);
        run(1, 500, 500);
        chk("lit_unlock_state", longint'(state), 1);
        chk("lit_unlock_ofs", longint'($signed(freq_ofs)), 0);
        chk("lit_unlock_clr", longint'(loop_clr), 1);
        chk("lit_unlock_locked", longint'(locked), 0);

        // Full sweep order and wrap
        for (int w = 0; w < NOFS; w++) begin
            run(WIN, 500, 500);
            chk("lit_sweep_ofs", longint'($signed(freq_ofs)), exp_seq[w]);
            chk("lit_sweep_clr", longint'(loop_clr), 1);
        end

        // Relock, then interleaved fail/pass windows keep lock
        run(1024, 1000, 0);
        chk("lit_relock", longint'(state), 3);
        for (int p = 0; p < 4; p++) begin
            run(WIN, 500, 500);
            run(WIN, 1000, 0);
        end
        run(WIN, 500, 500);
        run(WIN, 500, 500);
        run(WIN, 1000, 0);
        chk("lit_alt_locked", longint'(locked), 1);

        // en drop in PULL_IN at a nonzero offset keeps the offset
        sys_rst = 1'b1; run(1, 0, 0); sys_rst = 1'b0;
        run(1 + 3 * WIN, 500, 500);
        run(WIN, 1000, 0);
        chk("lit_pull_ofs", longint'(state), 2);
        run(100, 1000, 0);
        en = 1'b0;
        run(1, 1000, 0);
        chk("lit_en_idle", longint'(state), 0);
        chk("lit_en_ofs", longint'($signed(freq_ofs)), 171798);
        chk("lit_en_locked", longint'(locked), 0);
        en = 1'b1;
        run(1, 1000, 0);
        chk("lit_en_resweep_ofs", longint'($signed(freq_ofs)), 0);

        // Saturated magnitude still passes
        sys_rst = 1'b1; run(1, 0, 0); sys_rst = 1'b0;
        run(1 + WIN, -32768, -16383);
        chk("lit_sat_pull", longint'(state), 2);

        // Reset mid-window from TRACK
        sys_rst = 1'b1; run(1, 0, 0); sys_rst = 1'b0;
        run(1025, 1000, 0);
        chk("lit_pre_rst_track", longint'(state), 3);
        run(50, 1000, 0);
        sys_rst = 1'b1;
        run(1, 1000, 0);
        chk("lit_rst_state", longint'(state), 0);
        chk("lit_rst_locked", longint'(locked), 0);
        chk("lit_rst_kp", longint'(kp_shift), 4);
        chk("lit_rst_ki", longint'(ki_shift), 10);
        sys_rst = 1'b0;

        // Randomised epochs
        for (int e = 0; e < 40; e++) begin
            int mode;
            int len;
            mode = int'($urandom_range(0, 3));
            len  = int'($urandom_range(50, 1200));
            for (int k = 0; k < len; k++) begin
                int iv;
                int qv;
                sys_rst  = ($urandom_range(0, 1999) == 0);
                en       = ($urandom_range(0, 299) != 0);
                iq_valid = ($urandom_range(0, 4) != 0);
                case (mode)
                    0: begin
                        iv = int'($urandom_range(2000, 30000));
                        if ($urandom_range(0, 1) == 1) iv = -iv;
                        qv = int'($urandom_range(0, 500)) - 250;
                    end
                    1: begin iv = 500; qv = 500; end
                    2: begin iv = int'($urandom); qv = int'($urandom); end
                    default: begin iv = -32768; qv = int'($urandom_range(0, 32766)) - 16383; end
                endcase
                i_in = IQ_W'(iv);
                q_in = IQ_W'(qv);
                cyc();
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
